// File: rtl/datapath_pkg.sv
// Shared definitions for the bus-based datapath: ALU opcodes, RAM geometry and
// boot image, and the register-select decode helper.
package datapath_pkg;

  localparam int          RAM_DEPTH = 512;
  localparam int          RAM_AW    = 9;
  localparam logic [31:0] RAM_INIT0 = 32'h7118_0025;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00011,
    ALU_SUB  = 5'b00100,
    ALU_AND  = 5'b00101,
    ALU_OR   = 5'b00110,
    ALU_ROR  = 5'b00111,
    ALU_ROL  = 5'b01000,
    ALU_SHR  = 5'b01001,
    ALU_SHRA = 5'b01010,
    ALU_SHL  = 5'b01011,
    ALU_DIV  = 5'b01111,
    ALU_MUL  = 5'b10000,
    ALU_NEG  = 5'b10001,
    ALU_NOT  = 5'b10010
  } alu_op_e;

  function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
    reg_onehot = 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/datapath_if.sv
// Control and observation bundle of the datapath. The controller (master)
// drives enables every cycle; there is no handshake, the datapath samples
// the controls on each rising clock edge and all outputs are continuous.
interface datapath_if;
  logic [15:0] RX_in_man, RX_out_man;
  logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
  logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
  logic Read, Write;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0]  alu_instruction_bits;
  logic [31:0] InPort_Data_In;

  logic [15:0] RX_in, RX_out;
  logic        CON_out;
  logic [31:0] Outport_Data_Out;
  logic [31:0] Bus_Data, ALUHigh_Data, ALULow_Data;
  logic [31:0] R0_Data, R1_Data, R2_Data, R3_Data, R4_Data, R5_Data, R6_Data, R7_Data;
  logic [31:0] R8_Data, R9_Data, R10_Data, R11_Data, R12_Data, R13_Data, R14_Data, R15_Data;
  logic [31:0] PC_Data, IR_Data, Y_Data, Zhigh_Data, Zlow_Data, HI_Data, LO_Data;
  logic [31:0] MAR_Data, MDR_Data, InPort_Data, C_sign_extended_Data, Mdatain;

  modport master (
    output RX_in_man, RX_out_man, PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in,
           MDR_in, OutPort_in, IncPC, PC_out, Zhigh_out, Zlow_out, HI_out, LO_out,
           MDR_out, InPort_out, C_out, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
           alu_instruction_bits, InPort_Data_In,
    input  RX_in, RX_out, CON_out, Outport_Data_Out, Bus_Data, ALUHigh_Data, ALULow_Data,
           R0_Data, R1_Data, R2_Data, R3_Data, R4_Data, R5_Data, R6_Data, R7_Data,
           R8_Data, R9_Data, R10_Data, R11_Data, R12_Data, R13_Data, R14_Data, R15_Data,
           PC_Data, IR_Data, Y_Data, Zhigh_Data, Zlow_Data, HI_Data, LO_Data,
           MAR_Data, MDR_Data, InPort_Data, C_sign_extended_Data, Mdatain
  );

  modport slave (
    input  RX_in_man, RX_out_man, PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in,
           MDR_in, OutPort_in, IncPC, PC_out, Zhigh_out, Zlow_out, HI_out, LO_out,
           MDR_out, InPort_out, C_out, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
           alu_instruction_bits, InPort_Data_In,
    output RX_in, RX_out, CON_out, Outport_Data_Out, Bus_Data, ALUHigh_Data, ALULow_Data,
           R0_Data, R1_Data, R2_Data, R3_Data, R4_Data, R5_Data, R6_Data, R7_Data,
           R8_Data, R9_Data, R10_Data, R11_Data, R12_Data, R13_Data, R14_Data, R15_Data,
           PC_Data, IR_Data, Y_Data, Zhigh_Data, Zlow_Data, HI_Data, LO_Data,
           MAR_Data, MDR_Data, InPort_Data, C_sign_extended_Data, Mdatain
  );
endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus. Result is {high, low};
// only mul and div produce a non-zero high word.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  code,
  input  logic        inc_pc,
  output logic [63:0] result
);

  logic [31:0]        lo, hi;
  logic [4:0]         sh;
  logic [63:0]        rot_r, rot_l, prod;
  logic signed [31:0] den, quo, rem;
  logic               div_ovf;

  always_comb begin
    lo      = '0;
    hi      = '0;
    sh      = b[4:0];
    rot_r   = {a, a} >> sh;
    rot_l   = {a, a} << sh;
    prod    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    // Dividing by 1 in the zero and MIN/-1 cases keeps the divider defined;
    // MIN/1 is also the wrapped answer for MIN/-1.
    div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    den     = (b == '0 || div_ovf) ? 32'sd1 : $signed(b);
    quo     = $signed(a) / den;
    rem     = $signed(a) % den;
    if (inc_pc) begin
      lo = b + 32'd1;
    end else begin
      case (alu_op_e'(code))
        ALU_ADD:  lo = a + b;
        ALU_SUB:  lo = a - b;
        ALU_AND:  lo = a & b;
        ALU_OR:   lo = a | b;
        ALU_ROR:  lo = rot_r[31:0];
        ALU_ROL:  lo = rot_l[63:32];
        ALU_SHR:  lo = a >> sh;
        ALU_SHRA: lo = $unsigned($signed(a) >>> sh);
        ALU_SHL:  lo = a << sh;
        ALU_DIV: begin
          if (b == '0) begin
            lo = '1;
            hi = a;
          end else begin
            lo = $unsigned(quo);
            hi = $unsigned(rem);
          end
        end
        ALU_MUL:  {hi, lo} = prod;
        ALU_NEG:  lo = -b;
        ALU_NOT:  lo = ~b;
        default:  lo = b;
      endcase
    end
  end

  assign result = {hi, lo};

endmodule

// File: rtl/datapath.sv
// Single-bus datapath: sixteen GPRs, PC/IR/Y/Z/HI/LO, memory interface with a
// 512-word RAM, I/O port registers and the branch-condition flip-flop.
module datapath
  import datapath_pkg::*;
(
  input logic       clk,
  input logic       clr,
  datapath_if.slave dp
);

  logic [31:0] r [16];
  logic [31:0] pc_q, ir_q, y_q, zhi_q, zlo_q, hi_q, lo_q, mar_q, mdr_q;
  logic [31:0] inport_q, outport_q;
  logic        con_q, con_d;

  logic [15:0] dec, rx_in, rx_out;
  logic [31:0] bus, c_sext, r0_src, mdatain;
  logic [63:0] alu_res;

  logic [31:0] ram [RAM_DEPTH] = '{0: RAM_INIT0, default: 32'h0};

  always_comb begin
    dec = '0;
    if (dp.Gra) dec = dec | reg_onehot(ir_q[26:23]);
    if (dp.Grb) dec = dec | reg_onehot(ir_q[22:19]);
    if (dp.Grc) dec = dec | reg_onehot(ir_q[18:15]);
  end

  assign rx_in  = (dp.Rin ? dec : 16'h0) | dp.RX_in_man;
  assign rx_out = ((dp.Rout || dp.BAout) ? dec : 16'h0) | dp.RX_out_man;
  assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};
  // Base-address reads treat R0 as a hard zero.
  assign r0_src = dp.BAout ? 32'h0 : r[0];

  // Later assignments win, so the lowest-numbered register has top priority.
  always_comb begin
    bus = '0;
    if (dp.C_out)      bus = c_sext;
    if (dp.InPort_out) bus = inport_q;
    if (dp.MDR_out)    bus = mdr_q;
    if (dp.PC_out)     bus = pc_q;
    if (dp.Zlow_out)   bus = zlo_q;
    if (dp.Zhigh_out)  bus = zhi_q;
    if (dp.LO_out)     bus = lo_q;
    if (dp.HI_out)     bus = hi_q;
    for (int i = 15; i >= 1; i--) begin
      if (rx_out[i]) bus = r[i];
    end
    if (rx_out[0]) bus = r0_src;
  end

  datapath_alu u_alu (
    .a      (y_q),
    .b      (bus),
    .code   (dp.alu_instruction_bits),
    .inc_pc (dp.IncPC),
    .result (alu_res)
  );

  always_comb begin
    case (ir_q[20:19])
      2'b00:   con_d = (bus == 32'h0);
      2'b01:   con_d = (bus != 32'h0);
      2'b10:   con_d = ~bus[31];
      default: con_d = bus[31];
    endcase
  end

  assign mdatain = ram[mar_q[RAM_AW-1:0]];

  always_ff @(posedge clk) begin
    if (dp.Write) ram[mar_q[RAM_AW-1:0]] <= mdr_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) r[i] <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      y_q       <= '0;
      zhi_q     <= '0;
      zlo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      con_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (rx_in[i]) r[i] <= bus;
      end
      if (dp.PC_in)      pc_q      <= bus;
      if (dp.IR_in)      ir_q      <= bus;
      if (dp.Y_in)       y_q       <= bus;
      if (dp.HI_in)      hi_q      <= bus;
      if (dp.LO_in)      lo_q      <= bus;
      if (dp.MAR_in)     mar_q     <= bus;
      if (dp.OutPort_in) outport_q <= bus;
      if (dp.Z_in)       {zhi_q, zlo_q} <= alu_res;
      if (dp.MDR_in)     mdr_q     <= dp.Read ? mdatain : bus;
      inport_q <= dp.InPort_Data_In;
      con_q    <= con_d;
    end
  end

  assign dp.RX_in                = rx_in;
  assign dp.RX_out               = rx_out;
  assign dp.CON_out              = con_q;
  assign dp.Outport_Data_Out     = outport_q;
  assign dp.Bus_Data             = bus;
  assign dp.ALUHigh_Data         = alu_res[63:32];
  assign dp.ALULow_Data          = alu_res[31:0];
  assign dp.PC_Data              = pc_q;
  assign dp.IR_Data              = ir_q;
  assign dp.Y_Data               = y_q;
  assign dp.Zhigh_Data           = zhi_q;
  assign dp.Zlow_Data            = zlo_q;
  assign dp.HI_Data              = hi_q;
  assign dp.LO_Data              = lo_q;
  assign dp.MAR_Data             = mar_q;
  assign dp.MDR_Data             = mdr_q;
  assign dp.InPort_Data          = inport_q;
  assign dp.C_sign_extended_Data = c_sext;
  assign dp.Mdatain              = mdatain;
  assign dp.R0_Data              = r[0];
  assign dp.R1_Data              = r[1];
  assign dp.R2_Data              = r[2];
  assign dp.R3_Data              = r[3];
  assign dp.R4_Data              = r[4];
  assign dp.R5_Data              = r[5];
  assign dp.R6_Data              = r[6];
  assign dp.R7_Data              = r[7];
  assign dp.R8_Data              = r[8];
  assign dp.R9_Data              = r[9];
  assign dp.R10_Data             = r[10];
  assign dp.R11_Data             = r[11];
  assign dp.R12_Data             = r[12];
  assign dp.R13_Data             = r[13];
  assign dp.R14_Data             = r[14];
  assign dp.R15_Data             = r[15];

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the datapath: ori fetch/execute, mul/div corner cases,
// an ALU sweep scored against a reference model, R0/BAout, memory and clear.
module tb_datapath;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  datapath_if dif ();

  datapath dut (
    .clk (clk),
    .clr (clr),
    .dp  (dif.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctrl();
    dif.RX_in_man = '0;  dif.RX_out_man = '0;
    dif.PC_in = 0; dif.IR_in = 0; dif.Y_in = 0; dif.Z_in = 0; dif.HI_in = 0;
    dif.LO_in = 0; dif.MAR_in = 0; dif.MDR_in = 0; dif.OutPort_in = 0; dif.IncPC = 0;
    dif.PC_out = 0; dif.Zhigh_out = 0; dif.Zlow_out = 0; dif.HI_out = 0; dif.LO_out = 0;
    dif.MDR_out = 0; dif.InPort_out = 0; dif.C_out = 0; dif.Read = 0; dif.Write = 0;
    dif.Gra = 0; dif.Grb = 0; dif.Grc = 0; dif.Rin = 0; dif.Rout = 0; dif.BAout = 0;
    dif.alu_instruction_bits = '0;
  endtask

  // Latch v into the input port, then leave it driving the bus for the caller's load.
  task automatic drive_inport(input logic [31:0] v);
    clear_ctrl();
    dif.InPort_Data_In = v;
    tick();
    dif.InPort_out = 1;
  endtask

  task automatic set_y(input logic [31:0] v);
    drive_inport(v);
    dif.Y_in = 1;
    tick();
    clear_ctrl();
  endtask

  function automatic logic [63:0] alu_model(input logic [4:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0]        t;
    logic signed [31:0] q;
    logic signed [63:0] p;
    int                 n;
    n = int'(b[4:0]);
    t = a;
    case (code)
      5'b00011: return {32'h0, a + b};
      5'b00100: return {32'h0, a - b};
      5'b00101: return {32'h0, a & b};
      5'b00110: return {32'h0, a | b};
      5'b00111: begin for (int i = 0; i < n; i++) t = {t[0], t[31:1]}; return {32'h0, t}; end
      5'b01000: begin for (int i = 0; i < n; i++) t = {t[30:0], t[31]}; return {32'h0, t}; end
      5'b01001: return {32'h0, a >> n};
      5'b01010: begin for (int i = 0; i < n; i++) t = {t[31], t[31:1]}; return {32'h0, t}; end
      5'b01011: return {32'h0, a << n};
      5'b01111: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = $signed(a) / $signed(b);
        t = a - q * b;
        return {t, q};
      end
      5'b10000: begin p = $signed(a) * $signed(b); return p; end
      5'b10001: return {32'h0, 32'h0 - b};
      5'b10010: return {32'h0, ~b};
      default:  return {32'h0, b};
    endcase
  endfunction

  task automatic alu_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    set_y(a);
    drive_inport(b);
    dif.alu_instruction_bits = code;
    dif.Z_in = 1;
    exp_q.push_back(alu_model(code, a, b));
    tick();
    clear_ctrl();
    exp = exp_q.pop_front();
    check($sformatf("alu_%05b", code), {dif.Zhigh_Data, dif.Zlow_Data}, exp);
  endtask

  initial begin
    logic [4:0]  codes [15];
    logic [31:0] a, b;
    codes = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
              5'd15, 5'd16, 5'd17, 5'd18, 5'd0, 5'd31};
    clear_ctrl();
    dif.InPort_Data_In = '0;
    clr = 1;
    tick();
    tick();
    clr = 0;
    check("rst_pc", dif.PC_Data, 0);
    check("rst_r3", dif.R3_Data, 0);
    check("rst_zlow", dif.Zlow_Data, 0);
    check("rst_bus", dif.Bus_Data, 0);
    check("rst_con", dif.CON_out, 0);
    check("rst_mdatain", dif.Mdatain, 32'h7118_0025);

    // ori R2, R3, 0x25
    clear_ctrl();
    dif.InPort_Data_In = 32'hF1;
    dif.InPort_out = 1;
    dif.RX_in_man = 16'h0008;
    tick();
    tick();
    clear_ctrl();
    check("ori_r3", dif.R3_Data, 32'hF1);
    dif.PC_out = 1; dif.MAR_in = 1; dif.IncPC = 1; dif.Z_in = 1;
    tick(); clear_ctrl();
    dif.Zlow_out = 1; dif.PC_in = 1; dif.Read = 1; dif.MDR_in = 1;
    tick(); clear_ctrl();
    dif.MDR_out = 1; dif.IR_in = 1;
    tick(); clear_ctrl();
    check("ori_pc", dif.PC_Data, 1);
    check("ori_ir", dif.IR_Data, 32'h7118_0025);
    dif.Grb = 1; dif.Rout = 1; dif.Y_in = 1;
    #1;
    check("ori_rx_out", dif.RX_out, 16'h0008);
    tick(); clear_ctrl();
    check("ori_y", dif.Y_Data, 32'hF1);
    dif.C_out = 1; dif.alu_instruction_bits = 5'b00110; dif.Z_in = 1;
    #1;
    check("ori_csext", dif.Bus_Data, 32'h25);
    tick(); clear_ctrl();
    dif.Zlow_out = 1; dif.Gra = 1; dif.Rin = 1;
    #1;
    check("ori_rx_in", dif.RX_in, 16'h0004);
    tick(); clear_ctrl();
    check("ori_r2", dif.R2_Data, 32'hF5);

    // mul/div corner values
    alu_op(5'b10000, 32'hFFFF_FFFD, 32'd7);
    check("mul_hi", dif.Zhigh_Data, 32'hFFFF_FFFF);
    check("mul_lo", dif.Zlow_Data, 32'hFFFF_FFEB);
    alu_op(5'b01111, 32'd17, 32'hFFFF_FFFB);
    check("div_q", dif.Zlow_Data, 32'hFFFF_FFFD);
    check("div_r", dif.Zhigh_Data, 32'd2);
    alu_op(5'b01111, 32'd17, 32'd0);
    check("div0_q", dif.Zlow_Data, 32'hFFFF_FFFF);
    check("div0_r", dif.Zhigh_Data, 32'd17);

    for (int k = 0; k < 2; k++) begin
      foreach (codes[i]) begin
        a = $urandom;
        b = $urandom;
        if (codes[i] == 5'd15) b = (b[0] ? 32'h0 - $urandom_range(1, 999) : $urandom_range(1, 999));
        alu_op(codes[i], a, b);
      end
    end

    // R0 via BAout vs Rout; IR[20:19]=01 makes CON track bus != 0
    drive_inport(32'h55); dif.RX_in_man = 16'h0001; tick(); clear_ctrl();
    drive_inport(32'h0008_0000); dif.IR_in = 1; tick(); clear_ctrl();
    dif.Gra = 1; dif.BAout = 1;
    #1;
    check("baout_bus", dif.Bus_Data, 0);
    check("baout_rx_out", dif.RX_out, 16'h0001);
    tick();
    check("con_zero", dif.CON_out, 0);
    clear_ctrl();
    dif.Gra = 1; dif.Rout = 1;
    #1;
    check("rout_bus", dif.Bus_Data, 32'h55);
    tick(); clear_ctrl();
    check("con_nonzero", dif.CON_out, 1);

    // HI/LO/OutPort loads and bus priority (R1 beats HI)
    drive_inport(32'hA5A5_0001); dif.HI_in = 1; dif.OutPort_in = 1; tick(); clear_ctrl();
    check("outport", dif.Outport_Data_Out, 32'hA5A5_0001);
    drive_inport(32'h0BAD_0002); dif.LO_in = 1; dif.RX_in_man = 16'h0002; tick(); clear_ctrl();
    dif.HI_out = 1; dif.LO_out = 1;
    #1;
    check("prio_hi", dif.Bus_Data, 32'hA5A5_0001);
    dif.RX_out_man = 16'h0002;
    #1;
    check("prio_r1", dif.Bus_Data, 32'h0BAD_0002);
    clear_ctrl();

    // memory write then read back
    drive_inport(32'd5); dif.MAR_in = 1; tick(); clear_ctrl();
    drive_inport(32'hDEAD_BEEF); dif.MDR_in = 1; tick(); clear_ctrl();
    dif.Write = 1; tick(); clear_ctrl();
    drive_inport(32'h0); dif.MDR_in = 1; tick(); clear_ctrl();
    check("mdr_cleared", dif.MDR_Data, 0);
    dif.Read = 1; dif.MDR_in = 1; tick(); clear_ctrl();
    check("mem_read", dif.MDR_Data, 32'hDEAD_BEEF);

    // clear wins over simultaneous loads; RAM survives
    drive_inport(32'h1234);
    dif.RX_in_man = 16'hFFFF; dif.PC_in = 1; dif.Y_in = 1; dif.Z_in = 1; dif.OutPort_in = 1;
    clr = 1;
    tick();
    clr = 0;
    clear_ctrl();
    check("clr_r2", dif.R2_Data, 0);
    check("clr_r3", dif.R3_Data, 0);
    check("clr_pc", dif.PC_Data, 0);
    check("clr_ir", dif.IR_Data, 0);
    check("clr_y", dif.Y_Data, 0);
    check("clr_z", {dif.Zhigh_Data, dif.Zlow_Data}, 0);
    check("clr_mdr", dif.MDR_Data, 0);
    check("clr_mar", dif.MAR_Data, 0);
    check("clr_inport", dif.InPort_Data, 0);
    check("clr_outport", dif.Outport_Data_Out, 0);
    check("clr_hi", dif.HI_Data, 0);
    check("clr_con", dif.CON_out, 0);
    check("clr_ram0", dif.Mdatain, 32'h7118_0025);
    drive_inport(32'd5); dif.MAR_in = 1; tick(); clear_ctrl();
    check("clr_ram5", dif.Mdatain, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 clk  in  1  sole clock, all state updates on rising edge.
REQ-002 clr  in  1  synchronous, active-high reset.
REQ-003 RX_in_man, RX_out_man  in  16  manual one-hot register write/read enables (bit n = Rn).
REQ-004 PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC  in  1 each  register loads; IncPC forces ALU to bus+1.
REQ-005 PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out  in  1 each  bus drive selects.
REQ-006 Read, Write  in  1  memory read into MDR, write from MDR.
REQ-007 Gra, Grb, Grc, Rin, Rout, BAout  in  1  select-and-encode controls.
REQ-008 alu_instruction_bits  in  5  ALU operation code.
REQ-009 InPort_Data_In  in  32  external input-port data.
REQ-010 RX_in, RX_out  out  16  effective register write/read enables.
REQ-011 CON_out  out  1  branch-condition flip-flop.
REQ-012 Outport_Data_Out  out  32  output-port register.
REQ-013 Debug taps, out, 32 each: Bus_Data, ALUHigh_Data, ALULow_Data, R0_Data..R15_Data, PC_Data, IR_Data, Y_Data, Zhigh_Data, Zlow_Data, HI_Data, LO_Data, MAR_Data, MDR_Data, InPort_Data, C_sign_extended_Data, Mdatain.

Function
REQ-014 Bus: single source by priority R0..R15 (RX_out), HI, LO, Zhigh, Zlow, PC, MDR, InPort, C; none selected -> 0.
REQ-015 R0 drives 0 when read via BAout; otherwise R0 behaves as a normal register.
REQ-016 Select-encode: Gra->IR[26:23], Grb->IR[22:19], Grc->IR[18:15]; decoded one-hot OR'd across selects; RX_in = (Rin?dec:0)|RX_in_man; RX_out = ((Rout|BAout)?dec:0)|RX_out_man.
REQ-017 C_sign_extended_Data = IR[18:0] sign-extended to 32 bits.
REQ-018 Registers R0-R15, PC, IR, Y, HI, LO, MAR, OutPort load Bus_Data on enable at clk edge; Z_in loads Zhigh/Zlow from ALUHigh/ALULow.
REQ-019 ALU A = Y, B = Bus, combinational; codes: 00011 add, 00100 sub (A-B), 00101 and, 00110 or, 00111 ror, 01000 rol, 01001 shr, 01010 shra, 01011 shl (amount B[4:0]), 01111 div, 10000 mul, 10001 neg B, 10010 not B; other codes -> B.
REQ-020 Non-mul/div results on ALULow, ALUHigh = 0; add/sub wrap modulo 2^32.
REQ-021 mul: signed 64-bit product, high word ALUHigh, low ALULow.
REQ-022 div: signed; ALULow quotient, ALUHigh remainder (sign of dividend); B = 0 -> quotient 0xFFFFFFFF, remainder A.
REQ-023 IncPC overrides code: ALULow = B+1, ALUHigh = 0.
REQ-024 Memory: 512x32 RAM addressed MAR[8:0]; Mdatain = RAM[MAR] combinational; MDR_in loads Mdatain if Read else Bus; Write stores MDR into RAM[MAR] at clk edge.
REQ-025 RAM initial content: word 0 = 0x71180025, others 0; RAM not affected by clr.
REQ-026 InPort register loads InPort_Data_In every clk edge; InPort_Data shows it.
REQ-027 CON FF loads every edge: IR[20:19] 00 Bus==0, 01 Bus!=0, 10 Bus[31]==0, 11 Bus[31]==1.

Reset
REQ-028 clr high at edge: all registers, Z, InPort, OutPort, CON FF -> 0; clr dominates simultaneous loads.

Structure
REQ-029 Shared package holds ALU opcode constants and RAM depth/init word.
REQ-030 One sub-module natural: alu (A, B, code, IncPC -> 64-bit result).

Verification
REQ-031 ori: InPort=0xF1 with RX_in_man bit3 two cycles; fetch (PC_out,MAR_in,IncPC,Z_in; Zlow_out,PC_in,Read,MDR_in; MDR_out,IR_in); Grb,Rout,Y_in; C_out,code 00110,Z_in; Zlow_out,Gra,Rin -> R3=0xF1, PC=1, IR=0x71180025, R2=0xF5.
REQ-032 mul Y=-3, B=7 -> Zhigh=0xFFFFFFFF, Zlow=0xFFFFFFEB; div Y=17, B=-5 -> Zlow=-3, Zhigh=2; B=0 -> Zlow=0xFFFFFFFF.
REQ-033 BAout with Gra, IR[26:23]=0, R0=0x55 -> Bus=0; Rout same -> Bus=0x55.
REQ-034 Write: MAR=5, MDR=0xDEADBEEF, Write -> Read into MDR returns 0xDEADBEEF.
REQ-035 clr asserted mid-sequence -> all registers 0 next edge, RAM[0] still 0x71180025.
